// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU / loader) arbiter for the shared memory port.
// Optional atomic CPU lock hold enabled by defining MEM_ARB_LOCK_EN.
module mem_port_arbiter #(
    parameter int WIDTH        = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    input  logic             cpu_lock,
    output logic             cpu_gnt,
    output logic             cpu_rvalid,
    output logic [WIDTH-1:0] cpu_rdata,
    input  logic             ld_req,
    input  logic             ld_we,
    input  logic [WIDTH-1:0] ld_addr,
    input  logic [WIDTH-1:0] ld_wdata,
    output logic             ld_gnt,
    output logic             ld_rvalid,
    output logic [WIDTH-1:0] ld_rdata,
    output logic             mem_MemRead,
    output logic             mem_MemWrite,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_WrData,
    input  logic [WIDTH-1:0] mem_RdData
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic [3:0] starve_nxt;
    logic       rd_valid;
    logic       rd_id;
    logic       lock_hold;
    logic       ld_pri;
    logic       cpu_win;
    logic       ld_win;
    logic       cpu_sel;
    logic       ld_sel;
    logic       rd_now;

`ifdef MEM_ARB_LOCK_EN
    logic locked_q;

    // Lock only blocks the loader while the CPU keeps cpu_lock asserted
    assign lock_hold = locked_q & cpu_lock;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            locked_q <= 1'b0;
        else if (!cpu_lock)
            locked_q <= 1'b0;
        else if (cpu_win)
            locked_q <= 1'b1;
    end
`else
    logic unused_lock;

    assign lock_hold   = 1'b0;
    assign unused_lock = cpu_lock;
`endif

    assign ld_pri  = (starve_cnt == LIMIT) & ~lock_hold;
    assign cpu_win = cpu_req & ~(ld_req & ld_pri);
    assign ld_win  = ld_req & ~cpu_win & ~lock_hold;

    assign cpu_sel = rst & cpu_win;
    assign ld_sel  = rst & ld_win;
    assign rd_now  = (cpu_sel & ~cpu_we) | (ld_sel & ~ld_we);

    always_comb begin
        starve_nxt = starve_cnt;
        if (lock_hold)
            starve_nxt = starve_cnt;
        else if (!ld_req || ld_win)
            starve_nxt = 4'd0;
        else if (cpu_win && starve_cnt != LIMIT)
            starve_nxt = starve_cnt + 4'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= 4'd0;
            rd_valid   <= 1'b0;
            rd_id      <= 1'b0;
        end else begin
            starve_cnt <= starve_nxt;
            rd_valid   <= rd_now;
            rd_id      <= ld_win;
        end
    end

    assign cpu_gnt = cpu_sel;
    assign ld_gnt  = ld_sel;

    always_comb begin
        mem_MemRead  = 1'b0;
        mem_MemWrite = 1'b0;
        mem_addr     = '0;
        mem_WrData   = '0;
        unique case (1'b1)
            cpu_sel: begin
                mem_MemRead  = ~cpu_we;
                mem_MemWrite = cpu_we;
                mem_addr     = cpu_addr;
                mem_WrData   = cpu_wdata;
            end
            ld_sel: begin
                mem_MemRead  = ~ld_we;
                mem_MemWrite = ld_we;
                mem_addr     = ld_addr;
                mem_WrData   = ld_wdata;
            end
            default: begin
                mem_MemRead  = 1'b0;
                mem_MemWrite = 1'b0;
            end
        endcase
    end

    // Return path: only the registered read owner sees mem_RdData
    assign cpu_rvalid = rst & rd_valid & ~rd_id;
    assign ld_rvalid  = rst & rd_valid & rd_id;
    assign cpu_rdata  = cpu_rvalid ? mem_RdData : '0;
    assign ld_rdata   = ld_rvalid ? mem_RdData : '0;

endmodule
